// File: rtl/fp_pkg.sv
// Shared single-precision constants and the normalize-to-round stage payload.
// Used by fp_norm_round and the fp_adder/fp_sub/fp_madd/fp_msub datapaths.
package fp_pkg;

    localparam int          EXP_BIAS  = 127;
    localparam logic [7:0]  EXP_INF   = 8'hFF;
    localparam logic [22:0] QNAN_MANT = 23'h400000;

    // Wide enough for a 10-bit signed input exponent plus carry and a 26-bit left shift
    localparam int NEXP_W = 12;

    typedef struct packed {
        logic              sign;
        logic [NEXP_W-1:0] exp;
        logic [23:0]       sig;
        logic              g;
        logic              r;
        logic              s;
        logic              nan;
        logic              inf;
        logic              zero;
        logic              tiny;
    } norm_t;

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter over a 27-bit mantissa window.
// An all-zero input reports 27.
module fp_lzc (
    input  logic [26:0] din,
    output logic [4:0]  cnt
);

    always_comb begin
        cnt = 5'd27;
        // Scanning upward lets the highest set bit win
        for (int i = 0; i < 27; i++) begin
            if (din[i]) begin
                cnt = 5'(26 - i);
            end
        end
    end

endmodule

// File: rtl/fp_norm_round.sv
// Two-stage normalize / round-to-nearest-even unit feeding fp_pack.
// Define FP_DENORM_EN for gradual underflow; otherwise tiny results flush to zero.
module fp_norm_round
    import fp_pkg::*;
#(
    parameter int EXP_W  = 10,
    parameter int MANT_W = 28
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    input  logic              in_nan,
    input  logic              in_inf,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [7:0]        out_exp,
    output logic [22:0]       out_mant,
    output logic              out_overflow,
    output logic              out_underflow,
    output logic              out_inexact
);

    logic               s1_valid_reg;
    norm_t              s1_reg;
    logic               s2_valid_reg;
    logic               s2_ready;

    norm_t              n_next;
    logic [4:0]         lz;
    logic [26:0]        lshift;
    logic signed [NEXP_W-1:0] exp_ext;
    logic signed [NEXP_W-1:0] norm_exp;
    logic [26:0]        sig27;

`ifdef FP_DENORM_EN
    logic signed [NEXP_W-1:0] dist;
    logic [4:0]         sh;
    logic [26:0]        mask;
    logic [26:0]        rshift;
`endif

    assign s2_ready  = !s2_valid_reg || out_ready;
    assign in_ready  = !s1_valid_reg || s2_ready;
    assign out_valid = s2_valid_reg;

    assign exp_ext = {{(NEXP_W-EXP_W){in_exp[EXP_W-1]}}, in_exp};
    assign lshift  = in_mant[26:0] << lz;

    fp_lzc u_lzc (
        .din (in_mant[26:0]),
        .cnt (lz)
    );

    // Stage 1: normalize into {sig, G, R, S}
    always_comb begin
        n_next      = '0;
        norm_exp    = '0;
        sig27       = '0;
`ifdef FP_DENORM_EN
        dist        = '0;
        sh          = '0;
        mask        = '0;
        rshift      = '0;
`endif
        n_next.sign = in_sign;
        n_next.nan  = in_nan;
        n_next.inf  = in_inf && !in_nan;
        if (!in_nan && !in_inf) begin
            if (in_mant == '0) begin
                n_next.zero = 1'b1;
            end else begin
                if (in_mant[27]) begin
                    norm_exp = exp_ext + NEXP_W'(1);
                    sig27    = {in_mant[27:2], |in_mant[1:0]};
                end else begin
                    norm_exp = exp_ext - NEXP_W'(lz);
                    sig27    = lshift;
                end
                if (norm_exp <= 0) begin
`ifdef FP_DENORM_EN
                    // Denormalize: every bit pushed past S stays visible as sticky
                    dist     = NEXP_W'(1) - norm_exp;
                    sh       = (dist > 27) ? 5'd27 : dist[4:0];
                    mask     = (27'd1 << sh) - 27'd1;
                    rshift   = sig27 >> sh;
                    sig27    = {rshift[26:1], rshift[0] | (|(sig27 & mask))};
                    norm_exp = '0;
                    n_next.tiny = 1'b1;
`else
                    n_next.zero = 1'b1;
                    n_next.tiny = 1'b1;
`endif
                end
                n_next.exp = norm_exp;
                {n_next.sig, n_next.g, n_next.r, n_next.s} = sig27;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_reg       <= '0;
        end else if (in_ready) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_reg <= n_next;
            end
        end
    end

    // Stage 2: round to nearest even and classify
    logic               round_up;
    logic               inexact;
    logic [24:0]        sum;
    logic [NEXP_W-1:0]  rexp;
    logic               r_sign;
    logic [7:0]         r_exp;
    logic [22:0]        r_mant;
    logic               r_ovf;
    logic               r_uf;
    logic               r_inx;

    assign round_up = s1_reg.g & (s1_reg.r | s1_reg.s | s1_reg.sig[0]);
    assign inexact  = s1_reg.g | s1_reg.r | s1_reg.s;
    assign sum      = {1'b0, s1_reg.sig} + {24'd0, round_up};
    // A subnormal that rounds up into the hidden bit becomes the smallest normal
    assign rexp     = s1_reg.exp + NEXP_W'(sum[24])
                    + NEXP_W'((s1_reg.exp == '0) && sum[23]);

    always_comb begin
        r_sign = s1_reg.sign;
        r_exp  = 8'd0;
        r_mant = 23'd0;
        r_ovf  = 1'b0;
        r_uf   = 1'b0;
        r_inx  = 1'b0;
        if (s1_reg.nan) begin
            r_sign = 1'b0;
            r_exp  = EXP_INF;
            r_mant = QNAN_MANT;
        end else if (s1_reg.inf) begin
            r_exp  = EXP_INF;
        end else if (s1_reg.zero) begin
            r_uf   = s1_reg.tiny;
            r_inx  = s1_reg.tiny;
        end else if (rexp > NEXP_W'(2 * EXP_BIAS)) begin
            r_exp  = EXP_INF;
            r_ovf  = 1'b1;
            r_inx  = 1'b1;
        end else begin
            r_exp  = rexp[7:0];
            r_mant = sum[22:0];
            r_inx  = inexact;
            r_uf   = inexact & s1_reg.tiny;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid_reg  <= 1'b0;
            out_sign      <= 1'b0;
            out_exp       <= 8'd0;
            out_mant      <= 23'd0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_inexact   <= 1'b0;
        end else if (s2_ready) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                out_sign      <= r_sign;
                out_exp       <= r_exp;
                out_mant      <= r_mant;
                out_overflow  <= r_ovf;
                out_underflow <= r_uf;
                out_inexact   <= r_inx;
            end
        end
    end

endmodule

// File: tb/tb_fp_norm_round.sv
// Self-checking bench for fp_norm_round: arithmetic reference model plus directed literal vectors.
// Honours FP_DENORM_EN the same way the design does.
module tb_fp_norm_round;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
        logic        ovf;
        logic        uf;
        logic        inx;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [9:0]  in_exp = '0;
    logic [27:0] in_mant = '0;
    logic        in_nan = 1'b0;
    logic        in_inf = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [22:0] out_mant;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_inexact;

    int checks = 0;
    int failures = 0;
    bit rand_ready = 1'b0;
    res_t exp_q[$];
    res_t held;
    bit   held_valid = 1'b0;

    always #5 clk = ~clk;

    fp_norm_round #(.EXP_W(10), .MANT_W(28)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_exp        (in_exp),
        .in_mant       (in_mant),
        .in_nan        (in_nan),
        .in_inf        (in_inf),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_sign      (out_sign),
        .out_exp       (out_exp),
        .out_mant      (out_mant),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow),
        .out_inexact   (out_inexact)
    );

    function automatic res_t dut_res();
        return '{out_sign, out_exp, out_mant, out_overflow, out_underflow, out_inexact};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Value = m * 2^(e - 153); round that exact value to binary32 with RNE.
    function automatic res_t model(input bit s, input logic [9:0] e, input logic [27:0] m,
                                   input bit nan, input bit inf);
        res_t   r;
        int     p;
        int     en;
        int     k;
        int     re;
        longint mm;
        longint q;
        longint rem;
        longint half;
        r = '0;
        if (nan) begin
            r.exp = 8'd255; r.mant = 23'h400000;
            return r;
        end
        r.sign = s;
        if (inf) begin
            r.exp = 8'd255;
            return r;
        end
        if (m == 0) return r;
        p = 0;
        for (int i = 0; i < 28; i++) if (m[i]) p = i;
        en = int'($signed(e)) + p - 26;
        mm = longint'(m);
        if (en >= 1) begin
            k = p - 23;
        end else begin
`ifdef FP_DENORM_EN
            k = p - 23 + (1 - en);
`else
            r.uf = 1'b1; r.inx = 1'b1;
            return r;
`endif
        end
        if (k <= 0) begin
            q = mm << (-k); rem = 0; half = 64'd1 << 40;
        end else if (k >= 40) begin
            q = 0; rem = mm; half = 64'd1 << 39;
        end else begin
            q = mm >> k; rem = mm & ((64'd1 << k) - 1); half = 64'd1 << (k - 1);
        end
        r.inx = (rem != 0);
        if (rem > half || (rem == half && q[0])) q++;
        if (en >= 1) begin
            re = en;
            if (q == (64'd1 << 24)) begin q = q >> 1; re++; end
            if (re >= 255) begin
                r.exp = 8'd255; r.mant = '0; r.ovf = 1'b1; r.inx = 1'b1;
            end else begin
                r.exp = 8'(re); r.mant = q[22:0];
            end
        end else begin
            r.exp  = (q >= (64'd1 << 23)) ? 8'd1 : 8'd0;
            r.mant = q[22:0];
            r.uf   = r.inx;
        end
        return r;
    endfunction

    // Scoreboard and stall-stability monitor, sampled on the inactive edge
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            held_valid = 1'b0;
        end else begin
            if (held_valid && out_valid) chk("stall_stable", 64'(dut_res()), 64'(held));
            held_valid = out_valid && !out_ready;
            held = dut_res();
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(1), 64'(0));
                end else begin
                    chk("model_beat", 64'(dut_res()), 64'(exp_q.pop_front()));
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_sign, in_exp, in_mant, in_nan, in_inf));
        end
    end

    task automatic drive(input bit s, input logic [9:0] e, input logic [27:0] m,
                         input bit nan, input bit inf);
        bit acc;
        in_sign = s; in_exp = e; in_mant = m; in_nan = nan; in_inf = inf;
        in_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
            if (acc) return;
        end
        chk("accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic run_one(input string name, input bit s, input logic [9:0] e,
                           input logic [27:0] m, input bit nan, input bit inf, input res_t req);
        int lat;
        bit seen;
        drive(s, e, m, nan, inf);
        in_valid = 1'b0;
        seen = 1'b0;
        lat = 0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            lat++;
            if (out_valid) seen = 1'b1;
        end
        chk({name, "_latency"}, 64'(lat), 64'(2));
        chk(name, 64'(dut_res()), 64'(req));
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 40 && exp_q.size() != 0; t++) @(negedge clk);
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_outputs", 64'(dut_res()), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;

        run_one("one",       0, 10'd127, 28'h4000000, 0, 0, '{0, 8'd127, 23'd0, 0, 0, 0});
        run_one("carry",     0, 10'd127, 28'h8000000, 0, 0, '{0, 8'd128, 23'd0, 0, 0, 0});
        run_one("rne_tie",   0, 10'd127, 28'h7FFFFFC, 0, 0, '{0, 8'd128, 23'd0, 0, 0, 1});
        run_one("overflow",  0, 10'd254, 28'h7FFFFFC, 0, 0, '{0, 8'd255, 23'd0, 1, 0, 1});
        run_one("tie_even",  0, 10'd127, 28'h4000004, 0, 0, '{0, 8'd127, 23'd0, 0, 0, 1});
        run_one("round_up",  0, 10'd127, 28'h400000C, 0, 0, '{0, 8'd127, 23'd2, 0, 0, 1});
        run_one("left_norm", 1, 10'd130, 28'h0000100, 0, 0, '{1, 8'd112, 23'd0, 0, 0, 0});
        run_one("nan_wins",  1, 10'd3,   28'h1234567, 1, 1, '{0, 8'd255, 23'h400000, 0, 0, 0});
        run_one("inf",       1, 10'd3,   28'h1234567, 0, 1, '{1, 8'd255, 23'd0, 0, 0, 0});
        run_one("zero",      1, 10'd77,  28'h0000000, 0, 0, '{1, 8'd0, 23'd0, 0, 0, 0});
`ifdef FP_DENORM_EN
        run_one("underflow", 0, 10'd1,   28'h2000000, 0, 0, '{0, 8'd0, 23'h400000, 0, 0, 0});
`else
        run_one("underflow", 0, 10'd1,   28'h2000000, 0, 0, '{0, 8'd0, 23'd0, 0, 1, 1});
`endif

        // Backpressure: two beats fill the pipe, the third must wait
        out_ready = 1'b0;
        drive(0, 10'd127, 28'h4000000, 0, 0);
        drive(1, 10'd128, 28'h5000000, 0, 0);
        in_sign = 0; in_exp = 10'd129; in_mant = 28'h6000008; in_valid = 1'b1;
        @(negedge clk);
        chk("bp_in_ready", 64'(in_ready), 64'(0));
        chk("bp_out_valid", 64'(out_valid), 64'(1));
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        drive(0, 10'd129, 28'h6000008, 0, 0);
        in_valid = 1'b0;
        wait_drain();

        // Mixed traffic with random backpressure, checked only by the model
        rand_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            drive($urandom_range(0, 1), 10'($urandom_range(0, 340) - 40),
                  28'($urandom()), 0, ($urandom_range(0, 15) == 0));
        end
        in_valid = 1'b0;
        rand_ready = 1'b0;
        out_ready = 1'b1;
        wait_drain();

        // Reset with beats in flight discards them
        drive(0, 10'd100, 28'h4000000, 0, 0);
        drive(0, 10'd101, 28'h4000000, 0, 0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("midreset_out_valid", 64'(out_valid), 64'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midreset_in_ready", 64'(in_ready), 64'(1));
        repeat (4) @(negedge clk);
        chk("midreset_no_output", 64'(out_valid), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fp_norm_round.md
Name: fp_norm_round

Overview:
- Two-stage pipelined normalize-and-round unit for IEEE 754 single precision.
- Consumes the raw unnormalized sign/exponent/extended-mantissa result of the add/sub datapath.
- Produces rounded sign, exponent and fraction fields that feed fp_pack directly, plus status flags.
- Valid/ready handshake on both sides; shared by fp_adder, fp_sub, fp_madd and fp_msub.

Parameters:
- EXP_W, 10, width of signed (two's-complement) biased input exponent.
- MANT_W, 28, width of extended input mantissa: [27] carry, [26] hidden, [25:3] fraction, [2] G, [1] R, [0] S.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  unit can accept a beat
- in_sign  in  1  result sign
- in_exp  in  EXP_W  signed biased exponent
- in_mant  in  MANT_W  extended mantissa
- in_nan  in  1  upstream special-case: NaN result
- in_inf  in  1  upstream special-case: infinite result
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_sign  out  1  to fp_pack sign
- out_exp  out  8  to fp_pack exponent
- out_mant  out  23  to fp_pack mantissa
- out_overflow  out  1  result overflowed to infinity
- out_underflow  out  1  result tiny and inexact, or flushed to zero
- out_inexact  out  1  rounding discarded nonzero bits

Behaviour:
- Reset, synchronous: both stage valids are 0 and all outputs are 0.
- Reset mid-operation discards in-flight beats; in_ready = 1 on the first cycle after reset deasserts.
- Handshake:
  - Beat transfers when valid && ready.
  - Each stage advances when downstream is empty or accepting.
  - in_ready = !s1_valid || (!s2_valid || out_ready).
  - Output payload holds stable while out_valid && !out_ready.
- Latency: 2 cycles from input accept to out_valid with out_ready held high. Throughput is 1 beat/cycle.
- Stage 1 (normalize):
  - NaN: in_nan has priority over in_inf and over the mantissa.
  - Carry set (in_mant[27]=1): shift right 1, fold the shifted-out bit into S, exp+1.
  - Zero: mantissa == 0 gives a zero result carrying in_sign; no flags.
  - Otherwise: leading-zero count over [26:0], shift left by that count, exp -= count.
  - Exponent after normalization ≤ 0: handled per Optional Feature.
- Stage 2 (round, RNE):
  - round_up = G & (R | S | frac_lsb).
  - inexact = G | R | S.
  - Rounding carry past the hidden bit: exp+1, fraction = 0.
  - Exp ≥ 255 after rounding: infinity (exp 255, mant 0), overflow = 1, inexact = 1.
  - in_inf: exp 255, mant 0, sign = in_sign, no flags.
  - in_nan: canonical quiet NaN, sign 0, exp 255, mant 23'h400000, no flags.
- Simultaneous in_nan and in_inf: NaN wins.

Optional Feature:
- Macro: FP_DENORM_EN.
- Defined (gradual underflow):
  - When normalized exp ≤ 0: shift right by (1 − exp), capped at 27, ORing all shifted-out bits into S; exp = 0.
  - Round normally; rounding may promote the result to exp 1.
  - underflow = inexact && result subnormal before rounding.
- Undefined (flush to zero):
  - Any normalized exp ≤ 0 gives signed zero, underflow = 1, inexact = 1.

Decomposition:
- Shared package fp_pkg:
  - Constants EXP_BIAS = 127, EXP_INF = 8'hFF, QNAN_MANT = 23'h400000.
  - Struct typedef for the stage-1 → stage-2 payload: sign, exp, 24-bit significand, G/R/S, nan/inf/zero flags.
- Sub-module fp_lzc: combinational 27-bit leading-zero counter with 5-bit output, reused by multiply-add.

Test Plan:
- 1.0: sign 0, exp 127, mant 28'h4000000, out_ready = 1 → two cycles later exp 127, mant 0, no flags.
- Carry: exp 127, mant 28'h8000000 → exp 128, mant 0 (2.0), inexact 0.
- RNE tie rounds up to even: exp 127, mant 28'h7FFFFFC → exp 128, mant 0, inexact 1.
- Overflow: exp 254, mant 28'h7FFFFFC → exp 255, mant 0, overflow 1, inexact 1.
- Backpressure: out_ready = 0, three input beats offered → in_ready drops after two accepts; then out_ready = 1 → all three emerge in order, payload stable while stalled, no loss or duplicate.
- Underflow: exp 1, mant 28'h2000000:
  - Macro off → zero, underflow 1.
  - Macro on → exp 0, mant 23'h400000, underflow 0.
  - Also assert rst_n = 0 mid-stream → out_valid = 0 next cycle.
